// File: rtl/mem_sram_ctrl.sv
// MEM-stage to 16-bit SRAM bridge: each 32-bit load/store becomes two half-word
// SRAM cycles of WAIT clocks each, with ready low while the access is in flight.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR = 32'd1024,
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned WAIT      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned     CntW    = $clog2(WAIT) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        addr_off;
  logic               unused_addr_bits;
  logic               req;

  assign req      = mem_read | mem_write;
  assign addr_off = address - BASE_ADDR;
  // Byte offset and bits above the SRAM range are dropped; high addresses alias.
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_wr_d = mem_write;
          word_d  = addr_off[SRAM_AW:2];
          wdata_d = wdata;
          cnt_d   = CntLoad;
          state_d = StLo;
        end
      end
      StLo: begin
        if (cnt_q == '0) begin
          if (!op_wr_q) rdata_d[15:0] = sram_dq_i;
          cnt_d   = CntLoad;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHi: begin
        if (cnt_q == '0) begin
          if (!op_wr_q) rdata_d[31:16] = sram_dq_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // SRAM strobes decode only registered state, never the request inputs.
  always_comb begin
    ready      = (state_q == StDone) | ((state_q == StIdle) & ~req);
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    if ((state_q == StLo) || (state_q == StHi)) begin
      sram_addr = {word_q, state_q == StHi};
      if (op_wr_q) begin
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_dq_o  = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Multi-cycle controller sitting between the MEM stage of the ARM pipeline and a 16-bit-wide external SRAM. It accepts the stage's `mem_read`/`mem_write` strobes, sequences each 32-bit access as two half-word SRAM cycles with a programmable wait count, and returns the read word. While an access is in flight, `ready` is low; the hazard/freeze logic uses it to stall every pipeline register.

## Interface
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT`, 2: clock cycles per half-word access; must be ≥ 1.

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: MEM-stage load request (LDR).
- `mem_write` in 1: MEM-stage store request (STR).
- `address` in 32: byte address, computed by the ALU.
- `wdata` in 32: store data.
- `rdata` out 32: load result, registered.
- `ready` out 1: high when the MEM stage may advance.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_dq_o` out 16: write data to SRAM.
- `sram_dq_i` in 16: read data from SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_o`.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.

## Operation
- FSM has four states: IDLE, LO, HI, DONE. There is also a wait counter `cnt` of width clog2(WAIT)+1.
- **IDLE**
  - If `mem_read | mem_write`: latch `op` (write when `mem_write`; write wins if both are asserted), the word address and `wdata`.
  - Then load `cnt = WAIT-1` and go to LO.
- **Address mapping**
  - `word = (address - BASE_ADDR) >> 2`, computed modulo 2^32.
  - LO drives `sram_addr = {word[SRAM_AW-2:0], 1'b0}`.
  - HI drives `sram_addr = {word[SRAM_AW-2:0], 1'b1}`.
  - Upper bits are discarded, so out-of-range addresses alias silently.
- **LO**
  - Write: `sram_we_n=0`, `sram_dq_oe=1`, `sram_dq_o=wdata_q[15:0]`.
  - Read: `sram_oe_n=0`.
  - `cnt` decrements each cycle. At `cnt==0`: a read captures `sram_dq_i` into `rdata[15:0]`; reload `cnt=WAIT-1` and go to HI.
- **HI**: same as LO but with bits [31:16]. At `cnt==0`, go to DONE.
- **DONE**: all SRAM strobes inactive; `ready=1`; go to IDLE unconditionally.
- **`ready`** is combinational: `(state==DONE) | (state==IDLE & ~mem_read & ~mem_write)`. A new request therefore drops `ready` in the same cycle it appears.
- **SRAM outputs** are Moore decodes of the state and latched registers; they are never driven from the request inputs.
- `sram_dq_o` = 0 whenever `sram_dq_oe=0`.
- `rdata` holds its last value until the next read's half-word capture. Writes never change `rdata`.
- **Reset** (asynchronous, any state):
  - state=IDLE, cnt=0, `rdata=0`, latches=0.
  - Outputs become: `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `ready=1` (absent a request).
  - A write interrupted mid-cycle is abandoned and is not resumed after reset.

## Timing
- Request is first seen in cycle 0 (IDLE).
- LO occupies cycles 1..WAIT; HI occupies cycles WAIT+1..2·WAIT; DONE is cycle 2·WAIT+1.
- `ready` is low for 2·WAIT+1 cycles (cycles 0..2·WAIT) and high in DONE. The pipeline advances on the edge that ends DONE.
- With WAIT=2, `ready` is low in cycles 0–4 and high in cycle 5.
- Read data:
  - `rdata[15:0]` is valid from the edge that ends the last LO cycle.
  - The full `rdata` is valid from the edge ending the last HI cycle, so it is stable throughout DONE.
- Back-to-back: a request present in the cycle after DONE starts a new access immediately. There are no dead cycles other than DONE itself.
- Request inputs are sampled only in IDLE. Changes during LO/HI/DONE are ignored, because the pipeline is frozen.
- `sram_we_n` is low for exactly WAIT cycles per half-word. `sram_addr` and `sram_dq_o` are stable for the whole strobe.

## Test plan
- **Reset, idle:** hold `rst_n=0`, then release with no requests → `ready=1`, `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0`, `rdata=0`, every cycle.
- **Store, WAIT=2:** `mem_write=1`, `address=1032`, `wdata=32'hDEADBEEF` →
  - `ready` low in cycles 0–4, high in cycle 5.
  - `sram_addr=4` with `dq_o=16'hBEEF` and `we_n=0` in cycles 1–2.
  - `sram_addr=5` with `dq_o=16'hDEAD` and `we_n=0` in cycles 3–4.
- **Load after store:** SRAM model preloaded by the store above; `mem_read=1`, `address=1032` → `rdata=32'hDEADBEEF` in cycle 5, `sram_oe_n` low in cycles 1–4.
- **WAIT=1, back-to-back loads:** loads to 1024 and 1028, the second request asserted in the cycle after DONE → each access shows `ready` low for 3 cycles; the second access starts with no idle gap.
- **Reset mid-write:** assert `rst_n=0` in cycle 2 of a store → `sram_we_n=1` and `sram_dq_oe=0` immediately (asynchronously); after release, state is IDLE and `ready=1`; the SRAM high half-word is unchanged.
- **Simultaneous strobes and alias:** `mem_read=mem_write=1`, `address=1024 + 4·2^17` → treated as a write to `sram_addr` 0/1 (aliased); `rdata` is unchanged.
